// File: rtl/matrix_scanner.sv
// matrix_scanner: scans an 8x8 key/switch matrix one row at a time.
// Each row is driven low for SETTLE_CYCLES before its columns are sampled.
// A full 64-bit raw frame is debounced over DEBOUNCE_SCANS identical scans
// before it is published on FRAME, using the LED matrix driver bit layout.
// Optional feature macro: MATRIX_SCANNER_GHOST_EN. When it is defined, scans
// showing a ghosting rectangle are flagged on GHOST and never reach FRAME.
module matrix_scanner #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        OE,
    output logic [7:0]  ROW,
    input  logic [7:0]  COLUMN,
    output logic [63:0] FRAME,
    output logic        SCAN_DONE,
    output logic        CHANGED,
    output logic        GHOST
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  DEBOUNCE_N  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  row_idx;
    logic [15:0] settle_cnt;
    logic [7:0]  col_meta;
    logic [7:0]  col_sync;
    logic [63:0] raw;
    logic [63:0] last_raw;
    logic [3:0]  match_cnt;
    logic [3:0]  match_next;
    logic        row_last;
    logic        ghost_now;
    logic        frame_update;

    // A frame ghosts when two rows share two or more pressed columns.
    function automatic logic ghost_check(input logic [63:0] f);
        logic [7:0] both;
        logic       g;
        g = 1'b0;
        for (int i = 0; i < 7; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                both = f[i*8 +: 8] & f[j*8 +: 8];
                if ((both & (both - 8'd1)) != 8'd0) begin
                    g = 1'b1;
                end
            end
        end
        return g;
    endfunction

    assign row_last = (settle_cnt == SETTLE_LAST);

    // State register for the scan sequencer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and row drive; rows are only driven while in DRIVE.
    always_comb begin
        state_next = state;
        ROW        = 8'hFF;
        case (state)
            IDLE: begin
                if (OE) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                ROW = ~(8'd1 << row_idx);
                if (!OE) begin
                    state_next = IDLE;
                end else if (row_last && (row_idx == 3'd7)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = OE ? DRIVE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating count of consecutive identical scans, plus publish decision.
    always_comb begin
        match_next = 4'd1;
        if (raw == last_raw) begin
            match_next = (match_cnt >= DEBOUNCE_N) ? DEBOUNCE_N : match_cnt + 4'd1;
        end
`ifdef MATRIX_SCANNER_GHOST_EN
        ghost_now = ghost_check(raw);
`else
        ghost_now = 1'b0;
`endif
        frame_update = (match_next == DEBOUNCE_N) && (raw != FRAME) && !ghost_now;
    end

    // Column synchronizer, row sampling and the once-per-scan debounce update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col_meta   <= 8'hFF;
            col_sync   <= 8'hFF;
            row_idx    <= 3'd0;
            settle_cnt <= 16'd0;
            raw        <= 64'd0;
            last_raw   <= 64'd0;
            match_cnt  <= 4'd0;
            FRAME      <= 64'd0;
            SCAN_DONE  <= 1'b0;
            CHANGED    <= 1'b0;
        end else begin
            col_meta  <= COLUMN;
            col_sync  <= col_meta;
            SCAN_DONE <= 1'b0;
            CHANGED   <= 1'b0;
            case (state)
                IDLE: begin
                    row_idx    <= 3'd0;
                    settle_cnt <= 16'd0;
                    raw        <= 64'd0;
                    match_cnt  <= 4'd0;
                end
                DRIVE: begin
                    if (!OE) begin
                        row_idx    <= 3'd0;
                        settle_cnt <= 16'd0;
                        raw        <= 64'd0;
                        match_cnt  <= 4'd0;
                    end else if (row_last) begin
                        raw[{row_idx, 3'b000} +: 8] <= ~col_sync;
                        settle_cnt <= 16'd0;
                        if (row_idx != 3'd7) begin
                            row_idx <= row_idx + 3'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                DONE: begin
                    row_idx    <= 3'd0;
                    settle_cnt <= 16'd0;
                    match_cnt  <= match_next;
                    last_raw   <= raw;
                    SCAN_DONE  <= 1'b1;
                    if (frame_update) begin
                        FRAME   <= raw;
                        CHANGED <= 1'b1;
                    end
                end
                default: begin
                    row_idx    <= 3'd0;
                    settle_cnt <= 16'd0;
                end
            endcase
        end
    end

`ifdef MATRIX_SCANNER_GHOST_EN
    // Ghost flag for the most recently completed scan.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            GHOST <= 1'b0;
        end else if (state == DONE) begin
            GHOST <= ghost_now;
        end
    end
`else
    assign GHOST = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: directed bench for matrix_scanner with a behavioural
// key matrix. Runs one instance with DEBOUNCE_SCANS=3 and one with 1 side by
// side; expected per-scan results are queued as each scan's keys are applied.
module tb_matrix_scanner;

    logic        CLK;
    logic        RESET;
    logic        OE;
    logic [7:0]  row_a;
    logic [7:0]  col_a;
    logic [63:0] frame_a;
    logic        done_a;
    logic        changed_a;
    logic        ghost_a;
    logic [7:0]  row_b;
    logic [7:0]  col_b;
    logic [63:0] frame_b;
    logic        done_b;
    logic        changed_b;
    logic        ghost_b;
    logic [63:0] keys;

    int checks = 0;
    int fails  = 0;

`ifdef MATRIX_SCANNER_GHOST_EN
    localparam bit GHOST_BUILD = 1'b1;
`else
    localparam bit GHOST_BUILD = 1'b0;
`endif

    typedef struct {
        logic [63:0] frame;
        logic        changed;
        logic        ghost;
        logic [63:0] frame_d1;
        int          period;
    } expect_t;

    expect_t sb_q[$];

    matrix_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)) dut_a (
        .CLK(CLK), .RESET(RESET), .OE(OE), .ROW(row_a), .COLUMN(col_a),
        .FRAME(frame_a), .SCAN_DONE(done_a), .CHANGED(changed_a), .GHOST(ghost_a)
    );

    matrix_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .OE(OE), .ROW(row_b), .COLUMN(col_b),
        .FRAME(frame_b), .SCAN_DONE(done_b), .CHANGED(changed_b), .GHOST(ghost_b)
    );

    // Passive key matrix: a pressed key pulls its column low while its row is driven.
    function automatic logic [7:0] matrix_cols(input logic [7:0] row, input logic [63:0] k);
        logic [7:0] c;
        c = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (!row[r]) c = c & ~k[r*8 +: 8];
        end
        return c;
    endfunction

    assign col_a = matrix_cols(row_a, keys);
    assign col_b = matrix_cols(row_b, keys);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] k, input logic [63:0] f, input logic ch,
                                 input logic gh, input logic [63:0] f1, input int period);
        keys = k;
        sb_q.push_back('{frame: f, changed: ch, ghost: gh, frame_d1: f1, period: period});
    endtask

    task automatic checkOutput(input bit check_rows);
        int      cycles;
        int      stray;
        expect_t e;
        cycles = 0;
        stray  = 0;
        do begin
            @(negedge CLK);
            cycles++;
            if (changed_a && !done_a) stray++;
            if (check_rows && cycles <= 32)
                check64("row_seq", {56'd0, row_a},
                        {56'd0, (cycles < 32) ? ~(8'd1 << (cycles / 4)) : 8'hFF});
        end while (!done_a && cycles < 200);
        check64("scan_done_seen", {63'd0, done_a}, 64'd1);
        check64("stray_changed", 64'(stray), 64'd0);
        if (sb_q.size() == 0) begin
            check64("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check64("frame", frame_a, e.frame);
            check64("changed", {63'd0, changed_a}, {63'd0, e.changed});
            check64("ghost", {63'd0, ghost_a}, {63'd0, e.ghost});
            check64("frame_deb1", frame_b, e.frame_d1);
            check64("done_deb1", {63'd0, done_b}, 64'd1);
            if (e.period != 0) check64("scan_period", 64'(cycles), 64'(e.period));
        end
    endtask

    initial begin
        logic [63:0] ka;
        logic [63:0] kp;
        logic [63:0] kg;
        logic [63:0] kh;
        logic [63:0] g_frame;
        int          quiet;
        ka = 64'h0000_0000_0020_0000;
        kp = ka | 64'h0008_0000_0000_0000;
        kg = 64'h0000_0000_0000_0303;
        kh = 64'h0000_0000_0000_0103;
        g_frame = GHOST_BUILD ? 64'd0 : kg;

        RESET = 1'b1;
        OE    = 1'b1;
        keys  = 64'd0;
        repeat (3) @(negedge CLK);
        check64("rst_row", {56'd0, row_a}, 64'hFF);
        check64("rst_frame", frame_a, 64'd0);
        check64("rst_done", {63'd0, done_a}, 64'd0);
        check64("rst_changed", {63'd0, changed_a}, 64'd0);
        check64("rst_ghost", {63'd0, ghost_a}, 64'd0);

        // Idle matrix: two scans, the second with ROW sequence and period checks.
        applyStimulus(64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
        RESET = 1'b0;
        checkOutput(1'b0);
        applyStimulus(64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 33);
        checkOutput(1'b1);

        // Key (2,5) held: publishes on the third identical scan, then stays quiet.
        applyStimulus(ka, 64'd0, 1'b0, 1'b0, ka, 33); checkOutput(1'b0);
        applyStimulus(ka, 64'd0, 1'b0, 1'b0, ka, 33); checkOutput(1'b0);
        applyStimulus(ka, ka,    1'b1, 1'b0, ka, 33); checkOutput(1'b0);
        applyStimulus(ka, ka,    1'b0, 1'b0, ka, 33); checkOutput(1'b0);
        applyStimulus(ka, ka,    1'b0, 1'b0, ka, 33); checkOutput(1'b0);

        // Key (6,3) bounces: present, absent, then present for three scans.
        applyStimulus(kp, ka, 1'b0, 1'b0, kp, 33); checkOutput(1'b0);
        applyStimulus(ka, ka, 1'b0, 1'b0, ka, 33); checkOutput(1'b0);
        applyStimulus(kp, ka, 1'b0, 1'b0, kp, 33); checkOutput(1'b0);
        applyStimulus(kp, ka, 1'b0, 1'b0, kp, 33); checkOutput(1'b0);
        applyStimulus(kp, kp, 1'b1, 1'b0, kp, 33); checkOutput(1'b0);

        // Release everything, get two scans in, then drop OE mid-scan.
        applyStimulus(64'd0, kp, 1'b0, 1'b0, 64'd0, 33); checkOutput(1'b0);
        applyStimulus(64'd0, kp, 1'b0, 1'b0, 64'd0, 33); checkOutput(1'b0);
        repeat (9) @(negedge CLK);
        OE = 1'b0;
        @(negedge CLK);
        check64("oe_drop_row", {56'd0, row_a}, 64'hFF);
        check64("oe_drop_done", {63'd0, done_a}, 64'd0);
        check64("oe_drop_frame", frame_a, kp);
        quiet = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done_a || changed_a || (row_a != 8'hFF)) quiet++;
        end
        check64("oe_low_quiet", 64'(quiet), 64'd0);
        OE = 1'b1;
        applyStimulus(64'd0, kp,    1'b0, 1'b0, 64'd0, 0);  checkOutput(1'b0);
        applyStimulus(64'd0, kp,    1'b0, 1'b0, 64'd0, 33); checkOutput(1'b0);
        applyStimulus(64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 33); checkOutput(1'b0);

        // Rectangle of four keys, then release (1,1).
        applyStimulus(kg, 64'd0,   1'b0, GHOST_BUILD, g_frame, 33); checkOutput(1'b0);
        applyStimulus(kg, 64'd0,   1'b0, GHOST_BUILD, g_frame, 33); checkOutput(1'b0);
        applyStimulus(kg, g_frame, !GHOST_BUILD, GHOST_BUILD, g_frame, 33); checkOutput(1'b0);
        applyStimulus(kg, g_frame, 1'b0, GHOST_BUILD, g_frame, 33); checkOutput(1'b0);
        applyStimulus(kh, g_frame, 1'b0, 1'b0, kh, 33); checkOutput(1'b0);
        applyStimulus(kh, g_frame, 1'b0, 1'b0, kh, 33); checkOutput(1'b0);
        applyStimulus(kh, kh,      1'b1, 1'b0, kh, 33); checkOutput(1'b0);

        // Asynchronous reset in the middle of a scan.
        repeat (7) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check64("async_rst_frame", frame_a, 64'd0);
        check64("async_rst_row", {56'd0, row_a}, 64'hFF);
        check64("async_rst_frame_deb1", frame_b, 64'd0);
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
Name: matrix_scanner

Overview:
- Reader counterpart to the 8x8 LED matrix driver: scans an 8x8 key/switch matrix instead of lighting one.
- Drives one row at a time (active-low) and samples the 8 column inputs (active-low, externally pulled up).
- Assembles a 64-bit raw frame per scan and debounces at frame level.
- Publishes a stable 64-bit FRAME using the same bit layout the display side consumes, so pressed keys can be mirrored straight onto the LED matrix.

Parameters:
- SETTLE_CYCLES, 16: cycles each row is driven before its columns are sampled; legal range 3..65535 (2-flop sync plus 1).
- DEBOUNCE_SCANS, 3: consecutive identical scans required before FRAME updates; legal range 1..15; 1 = no debounce.

Ports:
- CLK  in  1  system clock, sole clock domain.
- RESET  in  1  asynchronous, active-high reset.
- OE  in  1  scan enable; low = matrix released, scanning stopped.
- ROW  out  8  row drive, active-low one-hot; 8'hFF = no row driven.
- COLUMN  in  8  column sense, active-low, asynchronous to CLK.
- FRAME  out  64  debounced key state; FRAME[r*8+c]=1 means key at row r, column c is pressed.
- SCAN_DONE  out  1  one-cycle pulse per completed scan.
- CHANGED  out  1  one-cycle pulse when FRAME takes a new value.
- GHOST  out  1  ghost flag for the last completed scan (see Optional Feature).

Behaviour:
- Reset values: ROW=8'hFF, FRAME=0, SCAN_DONE=0, CHANGED=0, GHOST=0, state=IDLE, raw=0, last_raw=0, match_cnt=0.
- COLUMN passes through a 2-flop synchronizer. Sampled bits are ~col_sync.
- States:
  - IDLE: ROW=8'hFF. If OE=1, go to DRIVE with row index r=0 on the next cycle.
  - DRIVE: ROW=~(1<<r) and settle counter runs. On the SETTLE_CYCLES-th cycle in DRIVE (the last cycle of the row), latch raw[r*8+:8] = ~col_sync.
    - r<7: increment r and stay in DRIVE; the counter restarts.
    - r=7: go to DONE.
  - DONE (1 cycle): ROW=8'hFF. Perform the debounce update, then go to DRIVE with r=0 if OE=1, else IDLE.
- Scan period with OE held high: 8*SETTLE_CYCLES+1 cycles.
- Debounce update in DONE, with outputs registered and visible on the following cycle:
  - Counter: if raw==last_raw, match_cnt=min(match_cnt+1, DEBOUNCE_SCANS); otherwise match_cnt=1.
  - last_raw <= raw.
  - SCAN_DONE pulses.
  - If the new match_cnt==DEBOUNCE_SCANS, raw!=FRAME, and the frame is not ghost-suppressed: FRAME <= raw and CHANGED pulses.
  - Because match_cnt saturates, a held key pattern causes no repeated CHANGED pulses.
- OE falling mid-scan: the next cycle shows ROW=8'hFF and state IDLE. The partial raw frame is discarded and match_cnt is cleared to 0. FRAME is held, and no SCAN_DONE or CHANGED is issued.
- OE rising: restart at row 0. Debounce restarts from match_cnt=0.
- RESET mid-scan: all state and outputs return to reset values immediately (asynchronous).
- Counter widths: settle counter 16 bits, match_cnt 4 bits, row index 3 bits with no wrap beyond 7.

Optional Feature:
- Macro: MATRIX_SCANNER_GHOST_EN.
- Defined:
  - In DONE, compute the ghost condition: any row pair i<j with popcount(raw_i & raw_j) >= 2.
  - GHOST registers that result, updated every DONE.
  - A ghosted scan never updates FRAME and never pulses CHANGED. It still updates last_raw/match_cnt and pulses SCAN_DONE.
- Not defined: ghost logic is absent, GHOST is tied to 0, and every debounced frame is eligible for update.

Test Plan:
- SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, OE=1 from reset, COLUMN=8'hFF:
  - ROW steps FE,FD,FB,...,7F at 4 cycles each, then FF for 1 cycle.
  - SCAN_DONE period is 33 cycles; FRAME stays 0 and CHANGED never fires.
- Key at row 2, column 5 held (COLUMN bit5 low while ROW=FB):
  - FRAME becomes 64'h0000_0000_0020_0000 after the 3rd identical scan, with exactly one CHANGED pulse.
  - No further CHANGED pulses while the key is held.
- Key bounces (present in scan 1, absent in scan 2, present in scans 3-5): FRAME updates only at the end of scan 5.
- DEBOUNCE_SCANS=1 with the same key: FRAME updates at the end of the first scan.
- OE dropped at cycle 10 of a scan:
  - ROW=FF on the next cycle, with no SCAN_DONE and FRAME unchanged.
  - After OE returns, 3 fresh identical scans are needed before any update.
- GHOST_EN build, keys (0,0),(0,1),(1,0),(1,1) pressed:
  - GHOST=1 after every scan, FRAME stays 0, no CHANGED.
  - Releasing (1,1): GHOST=0, and FRAME=64'h0000_0000_0000_0103 after 3 scans.
